// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns the PC, issues sequential word fetches and buffers
// returned instructions (with their PCs) for the decoder; redirects flush and drop stale data.
module fetch_queue #(
  parameter int unsigned          PC_WIDTH    = 32,
  parameter int unsigned          INSTR_WIDTH = 32,
  parameter int unsigned          DEPTH       = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic [PC_WIDTH-1:0]        redirect_pc,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [PC_WIDTH-1:0]        imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0]     imem_rsp_data,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [INSTR_WIDTH-1:0]     instr_out,
  output logic [PC_WIDTH-1:0]        instr_pc,
  output logic [$clog2(DEPTH):0]     outstanding
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthExt = DEPTH[CntW:0];

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  logic [PC_WIDTH-1:0]    pc_q   [DEPTH];
  logic [INSTR_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]       filled_q;

  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  ptr_t                head_q, head_d;
  ptr_t                tail_q, tail_d;
  ptr_t                fill_q, fill_d;
  cnt_t                count_q, count_d;
  cnt_t                out_q, out_d;
  cnt_t                drop_q, drop_d;

  logic          accept, pop, live_rsp;
  logic [CntW:0] credits_used;
  logic          unused_pc_low;

  assign unused_pc_low = ^redirect_pc[1:0];

  // Allocated entries plus responses still to be dropped must fit in the queue,
  // because the response channel cannot be stalled.
  assign credits_used   = {1'b0, count_q} + {1'b0, drop_q};
  assign imem_req_valid = !rst && !redirect && ({1'b0, count_q} < DepthExt) &&
                          (credits_used < DepthExt);
  assign imem_req_addr  = fetch_pc_q;

  assign instr_valid = (count_q != '0) && filled_q[head_q];
  assign instr_out   = (count_q != '0) ? data_q[head_q] : '0;
  assign instr_pc    = (count_q != '0) ? pc_q[head_q] : '0;
  assign outstanding = out_q;

  assign accept   = imem_req_valid && imem_req_ready;
  assign pop      = instr_valid && instr_ready && !redirect;
  assign live_rsp = imem_rsp_valid && (drop_q == '0) && !redirect;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    count_d    = count_q;
    drop_d     = drop_q;
    out_d      = out_q + cnt_t'(accept) - cnt_t'(imem_rsp_valid);
    if (redirect) begin
      fetch_pc_d = {redirect_pc[PC_WIDTH-1:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      count_d    = '0;
      // Everything still in flight after this cycle belongs to the old stream.
      drop_d     = out_d;
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
        tail_d     = tail_q + ptr_t'(1);
      end
      if (live_rsp) fill_d = fill_q + ptr_t'(1);
      if (pop)      head_d = head_q + ptr_t'(1);
      count_d = count_q + cnt_t'(accept) - cnt_t'(pop);
      if ((drop_q != '0) && imem_rsp_valid) drop_d = drop_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
      filled_q <= '0;
    end else if (redirect) begin
      filled_q <= '0;
    end else begin
      if (live_rsp) begin
        data_q[fill_q]   <= imem_rsp_data;
        filled_q[fill_q] <= 1'b1;
      end
      if (accept) begin
        pc_q[tail_q]     <= fetch_pc_q;
        data_q[tail_q]   <= '0;
        filled_q[tail_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(imem_rsp_valid && (out_q == '0)));
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a small in-order, fixed-latency instruction memory model.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic [2:0]  outstanding;

  int n_assert = 0;
  int n_fail   = 0;
  int lat      = 1;
  int cyc      = 0;
  int n_acc    = 0;
  int base;

  logic [31:0] mq_addr[$];
  int          mq_due[$];

  fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .outstanding    (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // Memory: a request accepted at edge k returns its data sampled at edge k+lat.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
      imem_rsp_valid <= 1'b0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + lat);
        n_acc <= n_acc + 1;
      end
      if (mq_due.size() > 0 && mq_due[0] <= cyc + 1) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= dat(mq_addr[0]);
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr_out", instr_out, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_outstanding", {29'b0, outstanding}, 32'd0);

    // 1: streaming, 1-cycle memory, decoder always ready
    @(negedge clk);
    rst = 1'b0;
    instr_ready = 1'b1;
    #1;
    chk("t1_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t1_addr0", imem_req_addr, 32'h0);
    @(negedge clk);
    chk("t1_out1", {29'b0, outstanding}, 32'd1);
    chk("t1_not_yet_valid", {31'b0, instr_valid}, 32'd0);
    chk("t1_addr4", imem_req_addr, 32'h4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_valid", {31'b0, instr_valid}, 32'd1);
      chk("t1_pc", instr_pc, 32'(4 * k));
      chk("t1_data", instr_out, dat(32'(4 * k)));
    end

    // 2: decoder stalled, queue fills then drains in order
    instr_ready = 1'b0;
    lat = 1;
    reset_pulse();
    base = n_acc;
    repeat (4) @(negedge clk);
    #1;
    chk("t2_req_stopped", {31'b0, imem_req_valid}, 32'd0);
    repeat (4) @(negedge clk);
    chk("t2_accepts", 32'(n_acc - base), 32'd4);
    chk("t2_out0", {29'b0, outstanding}, 32'd0);
    chk("t2_head_pc", instr_pc, 32'h0);
    chk("t2_head_data", instr_out, dat(32'h0));
    instr_ready = 1'b1;
    @(negedge clk);
    chk("t2_pc4", instr_pc, 32'h4);
    chk("t2_resume_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t2_resume_addr", imem_req_addr, 32'h10);
    @(negedge clk);
    chk("t2_pc8", instr_pc, 32'h8);
    @(negedge clk);
    chk("t2_pcC", instr_pc, 32'hC);
    @(negedge clk);
    chk("t2_pc10", instr_pc, 32'h10);
    chk("t2_data10", instr_out, dat(32'h10));
    @(negedge clk);
    chk("t2_pc14", instr_pc, 32'h14);

    // 3: 3-cycle memory, redirect with two requests in flight
    instr_ready = 1'b1;
    lat = 3;
    imem_req_ready = 1'b0;
    reset_pulse();
    redirect = 1'b1;
    redirect_pc = 32'h10;
    @(negedge clk);
    redirect = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    chk("t3_addr10", imem_req_addr, 32'h10);
    repeat (2) @(negedge clk);
    chk("t3_out2", {29'b0, outstanding}, 32'd2);
    chk("t3_addr18", imem_req_addr, 32'h18);
    redirect = 1'b1;
    redirect_pc = 32'h203;
    #1;
    chk("t3_no_req_in_redirect", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    chk("t3_out_after_redirect", {29'b0, outstanding}, 32'd2);
    #1;
    chk("t3_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t3_addr200", imem_req_addr, 32'h200);
    @(negedge clk);
    chk("t3_drop_first", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    chk("t3_drop_second", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    chk("t3_wait_live", {31'b0, instr_valid}, 32'd0);
    chk("t3_out3", {29'b0, outstanding}, 32'd3);
    @(negedge clk);
    chk("t3_valid", {31'b0, instr_valid}, 32'd1);
    chk("t3_pc200", instr_pc, 32'h200);
    chk("t3_data200", instr_out, dat(32'h200));

    // 4: redirect coinciding with a response and a pop
    instr_ready = 1'b1;
    lat = 1;
    imem_req_ready = 1'b1;
    reset_pulse();
    base = n_acc;
    repeat (2) @(negedge clk);
    chk("t4_head_pc0", instr_pc, 32'h0);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    #1;
    chk("t4_no_req", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    chk("t4_flushed", {31'b0, instr_valid}, 32'd0);
    chk("t4_out_zero_data", instr_out, 32'd0);
    chk("t4_out_zero_pc", instr_pc, 32'd0);
    chk("t4_outstanding0", {29'b0, outstanding}, 32'd0);
    chk("t4_accepts", 32'(n_acc - base), 32'd2);
    #1;
    chk("t4_addr100", imem_req_addr, 32'h100);
    repeat (2) @(negedge clk);
    chk("t4_pc100", instr_pc, 32'h100);
    chk("t4_data100", instr_out, dat(32'h100));

    // 5: PC wrap
    instr_ready = 1'b1;
    lat = 1;
    imem_req_ready = 1'b0;
    reset_pulse();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    chk("t5_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("t5_addr_wrap", imem_req_addr, 32'h0);
    @(negedge clk);
    chk("t5_pc_top", instr_pc, 32'hFFFF_FFFC);
    chk("t5_data_top", instr_out, dat(32'hFFFF_FFFC));
    @(negedge clk);
    chk("t5_pc_wrap", instr_pc, 32'h0);

    // 6: asynchronous reset with requests in flight and data queued
    instr_ready = 1'b0;
    lat = 3;
    imem_req_ready = 1'b1;
    reset_pulse();
    repeat (4) @(negedge clk);
    chk("t6_out3", {29'b0, outstanding}, 32'd3);
    chk("t6_head_valid", {31'b0, instr_valid}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_async_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("t6_async_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("t6_async_instr_out", instr_out, 32'd0);
    chk("t6_async_instr_pc", instr_pc, 32'd0);
    chk("t6_async_outstanding", {29'b0, outstanding}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lat = 1;
    instr_ready = 1'b1;
    #1;
    chk("t6_restart_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t6_restart_addr", imem_req_addr, 32'h0);
    chk("t6_restart_out", {29'b0, outstanding}, 32'd0);
    repeat (2) @(negedge clk);
    chk("t6_first_pc", instr_pc, 32'h0);
    chk("t6_first_data", instr_out, dat(32'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
